thread_ifetch_seq: RTL

- Instruction-fetch sequencer for the 4-thread CPU core; sits directly upstream of the fetch/register-access unit and drives its request port (f_enable/addr/thread/write_mode, returning data/ack).
- Keeps one program counter per thread and issues one read at a time, round-robin across eligible threads.
- Parks each returned word in a one-entry per-thread buffer.
- Presents buffered instructions to decode over a valid/ready port; handles per-thread PC redirects from branch resolution.

---
 rtl/thread_ifetch_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/thread_ifetch_seq.sv
// Four-thread instruction-fetch sequencer: round-robin PC issue to the fetch unit,
// one-entry per-thread instruction buffers, and a valid/ready port toward decode.
module thread_ifetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  thread_en,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_thread,
    input  logic [31:0] redirect_pc,
    output logic        f_enable,
    output logic        f_write_mode,
    output logic [31:0] f_addr,
    output logic [31:0] f_data_o,
    output logic [1:0]  f_thread,
    input  logic [31:0] f_data_i,
    input  logic        f_ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [1:0]  out_thread,
    output logic        fault_valid,
    output logic [1:0]  fault_thread
);
    localparam int NT = 4;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RELEASE} state_t;

    state_t                 state;
    logic [NT-1:0][31:0]    pc;
    logic [NT-1:0][31:0]    buf_instr;
    logic [NT-1:0][31:0]    buf_pc;
    logic [NT-1:0]          buf_vld;
    logic [NT-1:0]          halt;
    logic [1:0]             issue_ptr;
    logic [1:0]             out_ptr;
    logic                   discard;

    logic [NT-1:0]          redir_mask;
    logic [NT-1:0]          elig;
    logic [NT-1:0]          out_mask;
    logic [1:0]             issue_sel;
    logic [1:0]             out_sel;
    logic                   redir_hit;

    // First set bit at or after ptr, wrapping; lowest offset wins.
    function automatic logic [1:0] rr_pick(input logic [NT-1:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = NT-1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        redir_mask = redirect_valid ? (4'b0001 << redirect_thread) : 4'b0000;
        elig       = thread_en & ~buf_vld & ~halt & ~redir_mask;
        out_mask   = buf_vld & ~redir_mask;
        issue_sel  = rr_pick(elig, issue_ptr);
        out_sel    = rr_pick(out_mask, out_ptr);
        redir_hit  = redirect_valid && (redirect_thread == f_thread);
    end

    assign out_valid    = |out_mask;
    assign out_instr    = buf_instr[out_sel];
    assign out_pc       = buf_pc[out_sel];
    assign out_thread   = out_sel;
    assign f_write_mode = 1'b0;
    assign f_data_o     = 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= {NT{RESET_PC}};
            buf_instr    <= '0;
            buf_pc       <= '0;
            buf_vld      <= '0;
            halt         <= '0;
            issue_ptr    <= '0;
            out_ptr      <= '0;
            discard      <= 1'b0;
            f_enable     <= 1'b0;
            f_addr       <= '0;
            f_thread     <= '0;
            fault_valid  <= 1'b0;
            fault_thread <= '0;
        end else begin
            fault_valid <= 1'b0;

            if (out_valid && out_ready) begin
                buf_vld[out_sel] <= 1'b0;
                out_ptr          <= out_sel + 2'd1;
            end

            case (state)
                S_IDLE: begin
                    if (!f_ack && |elig) begin
                        // Reserved 0xF region: park the thread until a redirect revives it.
                        if (pc[issue_sel][31:28] == 4'hF) begin
                            fault_valid     <= 1'b1;
                            fault_thread    <= issue_sel;
                            halt[issue_sel] <= 1'b1;
                        end else begin
                            f_enable <= 1'b1;
                            f_addr   <= pc[issue_sel];
                            f_thread <= issue_sel;
                            discard  <= 1'b0;
                            state    <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (f_ack) begin
                        if (!discard && !redir_hit) begin
                            buf_vld[f_thread]   <= 1'b1;
                            buf_instr[f_thread] <= f_data_i;
                            buf_pc[f_thread]    <= f_addr;
                            pc[f_thread]        <= pc[f_thread] + PC_STEP;
                        end
                        issue_ptr <= f_thread + 2'd1;
                        f_enable  <= 1'b0;
                        discard   <= 1'b0;
                        state     <= S_RELEASE;
                    end else if (redir_hit) begin
                        discard <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!f_ack) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Placed last so a redirect overrides any fill or PC step above.
            if (redirect_valid) begin
                pc[redirect_thread]      <= redirect_pc;
                buf_vld[redirect_thread] <= 1'b0;
                halt[redirect_thread]    <= 1'b0;
            end
        end
    end
endmodule
